// File: rtl/dp_ram_bist_ctrl.sv
// March C- BIST controller and port arbiter for a 1R1W dual-port RAM.
// Optional macro DP_RAM_BIST_FAIL_LOG_EN adds FAIL_ADDR/FAIL_ELEM/FAIL_CNT.
module dp_ram_bist_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BITMASK_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     FAIL,
`ifdef DP_RAM_BIST_FAIL_LOG_EN
  output logic [ADDR_WIDTH-1:0]    FAIL_ADDR,
  output logic [2:0]               FAIL_ELEM,
  output logic [7:0]               FAIL_CNT,
`endif
  input  logic [ADDR_WIDTH-1:0]    F_AA,
  input  logic [ADDR_WIDTH-1:0]    F_AB,
  input  logic [DATA_WIDTH-1:0]    F_DB,
  input  logic [BITMASK_WIDTH-1:0] F_BWB,
  input  logic                     F_CEA,
  input  logic                     F_RDWENA,
  input  logic                     F_CEB,
  input  logic                     F_RDWENB,
  output logic [DATA_WIDTH-1:0]    F_QA,
  output logic [ADDR_WIDTH-1:0]    MEM_AA,
  output logic [ADDR_WIDTH-1:0]    MEM_AB,
  output logic [DATA_WIDTH-1:0]    MEM_DB,
  output logic [BITMASK_WIDTH-1:0] MEM_BWB,
  output logic                     MEM_CEA,
  output logic                     MEM_RDWENA,
  output logic                     MEM_CEB,
  output logic                     MEM_RDWENB,
  input  logic [DATA_WIDTH-1:0]    MEM_QA
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                  state_q, state_d;
  logic [2:0]              elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wr_ph_q, wr_ph_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic                    fail_q, fail_d;

  logic                    elem_down, elem_has_rd, elem_has_wr, at_term;
  logic                    do_read, do_write, mismatch, start_ok;
  logic [DATA_WIDTH-1:0]   rd_bg, wr_bg;
  logic [ADDR_WIDTH-1:0]   next_start;
  logic                    bist_cea, bist_ceb, bist_rdwenb;

  // Element table: M0 w0 | M1 r0w1 | M2 r1w0 | M3v r0w1 | M4v r1w0 | M5 r0
  assign elem_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
  assign elem_has_rd = (elem_q != 3'd0);
  assign elem_has_wr = (elem_q != 3'd5);
  assign rd_bg       = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
  assign wr_bg       = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
  assign at_term     = elem_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign next_start  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
  assign do_read     = (state_q == S_RUN) && elem_has_rd && !wr_ph_q;
  assign do_write    = (state_q == S_RUN) && elem_has_wr && (wr_ph_q || !elem_has_rd);
  assign mismatch    = rd_pend_q && (MEM_QA != exp_q);
  assign start_ok    = START && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    wr_ph_d     = wr_ph_q;
    rd_pend_d   = 1'b0;
    exp_d       = exp_q;
    fail_d      = fail_q | mismatch;
    bist_cea    = 1'b0;
    bist_ceb    = 1'b0;
    bist_rdwenb = 1'b1;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_RUN;
          elem_d  = 3'd0;
          addr_d  = '0;
          wr_ph_d = 1'b0;
          fail_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (do_read) begin
          bist_cea  = 1'b1;
          rd_pend_d = 1'b1;
          exp_d     = rd_bg;
        end
        if (do_write) begin
          bist_ceb    = 1'b1;
          bist_rdwenb = 1'b0;
        end
        // A read followed by a write keeps the address for one more cycle.
        if (do_read && elem_has_wr) begin
          wr_ph_d = 1'b1;
        end else begin
          wr_ph_d = 1'b0;
          if (at_term) begin
            if (elem_q == 3'd5) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_GAP;
              elem_d  = elem_q + 3'd1;
              addr_d  = next_start;
            end
          end else begin
            addr_d = elem_down ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
      end
      S_GAP:   state_d = S_RUN;
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      elem_q    <= '0;
      addr_q    <= '0;
      wr_ph_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      exp_q     <= '0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      addr_q    <= addr_d;
      wr_ph_q   <= wr_ph_d;
      rd_pend_q <= rd_pend_d;
      exp_q     <= exp_d;
      fail_q    <= fail_d;
    end
  end

  assign BUSY = (state_q == S_RUN) || (state_q == S_GAP) || (state_q == S_DRAIN);
  assign DONE = (state_q == S_DONE);
  assign FAIL = fail_q;

  assign MEM_AA     = BUSY ? addr_q      : F_AA;
  assign MEM_AB     = BUSY ? addr_q      : F_AB;
  assign MEM_DB     = BUSY ? wr_bg       : F_DB;
  assign MEM_BWB    = BUSY ? '1          : F_BWB;
  assign MEM_CEA    = BUSY ? bist_cea    : F_CEA;
  assign MEM_RDWENA = BUSY ? 1'b1        : F_RDWENA;
  assign MEM_CEB    = BUSY ? bist_ceb    : F_CEB;
  assign MEM_RDWENB = BUSY ? bist_rdwenb : F_RDWENB;
  assign F_QA       = MEM_QA;

`ifdef DP_RAM_BIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] fail_addr_q, rd_addr_q;
  logic [2:0]            fail_elem_q, rd_elem_q;
  logic [7:0]            fail_cnt_q;

  // The read's address/element are held so the compare a cycle later logs the right site.
  always_ff @(posedge CLK) begin
    if (RST || start_ok) begin
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_cnt_q  <= '0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
    end else begin
      if (do_read) begin
        rd_addr_q <= addr_q;
        rd_elem_q <= elem_q;
      end
      if (mismatch) begin
        if (fail_cnt_q == 8'd0) begin
          fail_addr_q <= rd_addr_q;
          fail_elem_q <= rd_elem_q;
        end
        if (fail_cnt_q != 8'hFF) fail_cnt_q <= fail_cnt_q + 8'd1;
      end
    end
  end

  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_ELEM = fail_elem_q;
  assign FAIL_CNT  = fail_cnt_q;
`endif

endmodule

// File: doc/dp_ram_bist_ctrl.md
Name: dp_ram_bist_ctrl

Overview:
- Memory built-in self-test controller and port arbiter for the 1R1W dual-port RAM (port A read, port B masked write).
- Idle: functional requester passes straight through to the RAM ports.
- On START: takes over both ports, runs a March C- sequence, compares read data, reports pass/fail.
- Instantiated beside each RAM macro wrapper; START/DONE/FAIL go to the SoC test controller.

Parameters:
ADDR_WIDTH, 4, RAM address width; N = 2**ADDR_WIDTH words.
DATA_WIDTH, 32, RAM word width.
BITMASK_WIDTH, 32, write bit-mask width; must equal DATA_WIDTH.

Ports:
CLK  input  1  single clock for controller and RAM (CLKA/CLKB tied to it).
RST  input  1  synchronous, active-high reset.
START  input  1  level-sampled; begins a test when sampled high in IDLE or DONE.
BUSY  output  1  test in progress; BIST owns the RAM ports.
DONE  output  1  test finished; held until next START or RST.
FAIL  output  1  sticky mismatch flag; valid when DONE=1.
F_AA, F_AB  input  ADDR_WIDTH  functional read/write addresses.
F_DB  input  DATA_WIDTH  functional write data.
F_BWB  input  BITMASK_WIDTH  functional write bit mask.
F_CEA, F_RDWENA, F_CEB, F_RDWENB  input  1  functional enables.
F_QA  output  DATA_WIDTH  functional read data; equals MEM_QA.
MEM_AA, MEM_AB  output  ADDR_WIDTH  to RAM AA/AB.
MEM_DB  output  DATA_WIDTH  to RAM DB.
MEM_BWB  output  BITMASK_WIDTH  to RAM BWB.
MEM_CEA, MEM_RDWENA, MEM_CEB, MEM_RDWENB  output  1  to RAM enables.
MEM_QA  input  DATA_WIDTH  from RAM QA.

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state IDLE, BUSY=0, DONE=0, FAIL=0, all internal counters 0.
- RST mid-test aborts immediately. Port mux returns to functional in the cycle after the reset edge. RAM contents are left as-is.
- States: IDLE -> RUN -> GAP -> RUN ... -> DRAIN -> DONE.
  - START in IDLE/DONE: go to RUN with element 0, addr 0; clear FAIL and DONE.
  - START while BUSY: ignored.
- Port mux (combinational on registered state):
  - BUSY=0: MEM_* = F_*.
  - BUSY=1: BIST drives MEM_*. Functional inputs are ignored.
  - Unused BIST enables: MEM_CEA=0, MEM_CEB=0, MEM_RDWENB=1.
- BIST writes: MEM_BWB all ones. Data backgrounds: 0 = all zeros, 1 = all ones.
- Elements:
  - M0 up w0.
  - M1 up r0,w1.
  - M2 up r1,w0.
  - M3 down r0,w1.
  - M4 down r1,w0.
  - M5 up r0.
- Op timing:
  - w-only and r-only elements: 1 cycle per address.
  - r,w elements: 2 cycles per address, read cycle (CEA=1, RDWENA=1, AA=a) then write cycle (CEB=1, RDWENB=0, AB=a).
- Address counter:
  - Up elements count 0..N-1. Down elements count N-1..0.
  - Element ends at the terminal address; the counter wraps to the start address of the next element.
- Gaps and drain:
  - One GAP cycle (no enables) after each of M0-M4, 5 total.
  - After the last M5 read, one DRAIN cycle for the final compare.
- Read latency 1: QA is valid the cycle after the read.
  - Controller registers read-issued and expected value.
  - Compares MEM_QA against expected the next cycle (during the write/GAP/DRAIN/next-read cycle).
  - Mismatch sets FAIL (sticky).
- Test always runs to completion; no stop-on-fail.
- BUSY is high for exactly 10N+6 cycles. DONE rises in the cycle BUSY falls.

Optional Feature:
- Macro DP_RAM_BIST_FAIL_LOG_EN.
- Defined: adds outputs FAIL_ADDR [ADDR_WIDTH], FAIL_ELEM [3] and FAIL_CNT [8].
  - FAIL_ADDR and FAIL_ELEM capture the first mismatch only.
  - FAIL_CNT counts mismatching reads, saturating at 255.
  - All three reset to 0 and clear on START.
- Undefined: ports and logic absent; FAIL only.

Test Plan:
- ADDR_WIDTH=2, DATA_WIDTH=8, fault-free RAM, START pulse -> BUSY high 46 cycles, then DONE=1, FAIL=0; DONE holds until next START.
- Same config, bench forces MEM_QA[0]=1 whenever a read of addr 2 returns -> FAIL=1 at DONE; with log: FAIL_ADDR=2, FAIL_ELEM=1, FAIL_CNT=3 (M1, M3, M5 reads at addr 2).
- Idle pass-through: drive F_CEB=1, F_RDWENB=0, F_AB=1, F_DB=0xA5, F_BWB=0xFF, then F_CEA=1, F_RDWENA=1, F_AA=1 -> F_QA=0xA5 one cycle after the read; MEM_* mirror F_* each cycle.
- Assert RST 10 cycles after START -> next cycle BUSY=0, DONE=0, FAIL=0, MEM_* = F_*; a new START runs a full 46-cycle test.
- START re-pulsed at cycle 20 of a test -> ignored, BUSY still totals 46 cycles; START while DONE=1 -> DONE/FAIL clear and a new test begins.
